// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard and forwarding controller for the ARM pipeline. It keeps one
// scoreboard entry for each in-flight stage after ID (1 = EXE, 2 = MEM,
// 3 = WB, ...). Each entry records the destination of the instruction in that
// stage. From the entries it produces:
//   - the ID stall (hazard) and the IF/ID + ID/EXE flush;
//   - operand-forwarding selects for the instruction now in EXE;
//   - saturating counters of stall cycles and flush events.
//
// Parameters
//   STAGES : in-flight stages tracked after ID (2..6)
//   REG_W  : register-address width
//   FWD_EN : 1 = forwarding mode (only load-use stalls), 0 = stall-only mode
//   RF_WT  : 1 = register file writes before reads, so the last stage is
//            left out of the hazard check
//   CNT_W  : width of each performance counter
//
// Ports
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   id_valid     : ID holds a real instruction
//   id_wb_en     : ID instruction writes a register
//   id_mem_r_en  : ID instruction is a load
//   id_dest      : ID destination register
//   id_src1      : Rn
//   id_src1_en   : Rn is read
//   id_src2      : Rm / Rd-for-store
//   id_two_src   : src2 is read
//   branch_taken : instruction in EXE redirects the PC
//   freeze_ext   : global hold (e.g. memory wait)
//   hazard       : stall IF, IF-reg and ID; bubble into EXE (combinational)
//   flush        : clear IF/ID and ID/EXE registers (combinational)
//   fwd_sel1     : forwarding source for EXE Rn (0 = register file)
//   fwd_sel2     : forwarding source for EXE Rm (0 = register file)
//   stall_cnt    : saturating count of hazard cycles
//   flush_cnt    : saturating count of flush cycles
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int STAGES = 3,
    parameter int REG_W  = 4,
    parameter int FWD_EN = 1,
    parameter int RF_WT  = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic [REG_W-1:0] id_dest,
    input  logic [REG_W-1:0] id_src1,
    input  logic             id_src1_en,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             branch_taken,
    input  logic             freeze_ext,
    output logic             hazard,
    output logic             flush,
    output logic [2:0]       fwd_sel1,
    output logic [2:0]       fwd_sel2,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // A source depends on an entry when the entry is a live register writer
    // whose destination equals that (enabled) source.
    function automatic logic live_match(
        input logic             v,
        input logic             wb,
        input logic [REG_W-1:0] dest,
        input logic [REG_W-1:0] src,
        input logic             src_en
    );
        return v & wb & src_en & (dest == src);
    endfunction

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Scoreboard entries, index 1 = EXE
    logic [STAGES:1]  r_v;
    logic [STAGES:1]  r_wb;
    logic [STAGES:1]  r_ld;
    logic [REG_W-1:0] r_dest [1:STAGES];

    // Source fields of the EXE instruction, needed to pick forwarding paths
    logic [REG_W-1:0] r_e1_src1;
    logic             r_e1_src1_en;
    logic [REG_W-1:0] r_e1_src2;
    logic             r_e1_two_src;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Per-entry dependency of the ID sources and of the EXE sources
    logic [STAGES:1]  w_id_hit1;
    logic [STAGES:1]  w_id_hit2;
    logic [STAGES:1]  w_ex_hit1;
    logic [STAGES:1]  w_ex_hit2;

    logic             w_raw;
    logic             w_load_use;
    logic             w_need_stall;
    logic             w_hazard;
    logic             w_flush;
    logic [2:0]       w_fwd1;
    logic [2:0]       w_fwd2;

    // Compare every entry against the ID sources and the EXE sources
    always_comb begin
        w_id_hit1 = '0;
        w_id_hit2 = '0;
        w_ex_hit1 = '0;
        w_ex_hit2 = '0;
        for (int k = 1; k <= STAGES; k++) begin
            w_id_hit1[k] = live_match(r_v[k], r_wb[k], r_dest[k], id_src1, id_src1_en);
            w_id_hit2[k] = live_match(r_v[k], r_wb[k], r_dest[k], id_src2, id_two_src);
            w_ex_hit1[k] = live_match(r_v[k], r_wb[k], r_dest[k], r_e1_src1, r_e1_src1_en);
            w_ex_hit2[k] = live_match(r_v[k], r_wb[k], r_dest[k], r_e1_src2, r_e1_two_src);
        end
    end

    // Stall and flush decisions; flush masks the stall, freeze masks both
    always_comb begin
        w_raw = 1'b0;
        for (int k = 1; k <= STAGES; k++) begin
            // With write-before-read the last stage delivers its value through
            // the register file in time, so it cannot block ID.
            w_raw = w_raw | ((w_id_hit1[k] | w_id_hit2[k]) & (k <= STAGES - RF_WT));
        end
        // A load in EXE has no data to forward until it reaches a later stage.
        w_load_use = r_ld[1] & (w_id_hit1[1] | w_id_hit2[1]);
        if (FWD_EN != 0) begin
            w_need_stall = w_load_use;
        end else begin
            w_need_stall = w_raw;
        end
        // Gating with rst keeps both outputs at 0 while reset is held.
        w_flush  = rst & branch_taken & ~freeze_ext;
        w_hazard = rst & id_valid & w_need_stall & ~branch_taken & ~freeze_ext;
    end

    // Forwarding selects for the EXE operands: youngest matching stage wins
    always_comb begin
        w_fwd1 = 3'd0;
        w_fwd2 = 3'd0;
        if (FWD_EN != 0) begin
            // Walk oldest to youngest so a younger match overrides an older one.
            // A load in stage 2 is skipped: its data only exists from stage 3.
            for (int k = STAGES; k >= 2; k--) begin
                w_fwd1 = (w_ex_hit1[k] && ((k >= 3) || !r_ld[k])) ? 3'(k) : w_fwd1;
                w_fwd2 = (w_ex_hit2[k] && ((k >= 3) || !r_ld[k])) ? 3'(k) : w_fwd2;
            end
        end else begin
            w_fwd1 = 3'd0;
            w_fwd2 = 3'd0;
        end
    end

    // Scoreboard shift: entries move one stage per unfrozen cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v          <= '0;
            r_wb         <= '0;
            r_ld         <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                r_dest[k] <= '0;
            end
            r_e1_src1    <= '0;
            r_e1_src1_en <= 1'b0;
            r_e1_src2    <= '0;
            r_e1_two_src <= 1'b0;
        end else if (!freeze_ext) begin
            r_v[STAGES:2]  <= r_v[STAGES-1:1];
            r_wb[STAGES:2] <= r_wb[STAGES-1:1];
            r_ld[STAGES:2] <= r_ld[STAGES-1:1];
            for (int k = 2; k <= STAGES; k++) begin
                r_dest[k] <= r_dest[k-1];
            end
            if (id_valid && !w_hazard && !w_flush) begin
                r_v[1]       <= 1'b1;
                r_wb[1]      <= id_wb_en;
                r_ld[1]      <= id_mem_r_en;
                r_dest[1]    <= id_dest;
                r_e1_src1    <= id_src1;
                r_e1_src1_en <= id_src1_en;
                r_e1_src2    <= id_src2;
                r_e1_two_src <= id_two_src;
            end else begin
                // Bubble: clear all fields so it can never match anything.
                r_v[1]       <= 1'b0;
                r_wb[1]      <= 1'b0;
                r_ld[1]      <= 1'b0;
                r_dest[1]    <= '0;
                r_e1_src1    <= '0;
                r_e1_src1_en <= 1'b0;
                r_e1_src2    <= '0;
                r_e1_two_src <= 1'b0;
            end
        end
    end

    // Saturating stall and flush counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_hazard && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (w_flush && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign hazard    = w_hazard;
    assign flush     = w_flush;
    assign fwd_sel1  = w_fwd1;
    assign fwd_sel2  = w_fwd2;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//
// Directed bench for hazard_scoreboard. Three instances share one stimulus
// bus: stall-only (u_stall), forwarding (u_fwd) and stall-only with 2-bit
// counters (u_sat). Each scenario starts from reset and checks only the
// instance it is written for.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic       id_wb_en;
    logic       id_mem_r_en;
    logic [3:0] id_dest;
    logic [3:0] id_src1;
    logic       id_src1_en;
    logic [3:0] id_src2;
    logic       id_two_src;
    logic       branch_taken;
    logic       freeze_ext;

    logic        s_haz, s_flush;
    logic [2:0]  s_fs1, s_fs2;
    logic [15:0] s_scnt, s_fcnt;

    logic        f_haz, f_flush;
    logic [2:0]  f_fs1, f_fs2;
    logic [15:0] f_scnt, f_fcnt;

    logic        t_haz, t_flush;
    logic [2:0]  t_fs1, t_fs2;
    logic [1:0]  t_scnt, t_fcnt;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_scoreboard #(.STAGES(3), .REG_W(4), .FWD_EN(0), .RF_WT(1), .CNT_W(16)) u_stall (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .id_src1(id_src1),
        .id_src1_en(id_src1_en), .id_src2(id_src2), .id_two_src(id_two_src),
        .branch_taken(branch_taken), .freeze_ext(freeze_ext),
        .hazard(s_haz), .flush(s_flush), .fwd_sel1(s_fs1), .fwd_sel2(s_fs2),
        .stall_cnt(s_scnt), .flush_cnt(s_fcnt)
    );

    hazard_scoreboard #(.STAGES(3), .REG_W(4), .FWD_EN(1), .RF_WT(1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .id_src1(id_src1),
        .id_src1_en(id_src1_en), .id_src2(id_src2), .id_two_src(id_two_src),
        .branch_taken(branch_taken), .freeze_ext(freeze_ext),
        .hazard(f_haz), .flush(f_flush), .fwd_sel1(f_fs1), .fwd_sel2(f_fs2),
        .stall_cnt(f_scnt), .flush_cnt(f_fcnt)
    );

    hazard_scoreboard #(.STAGES(3), .REG_W(4), .FWD_EN(0), .RF_WT(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .id_src1(id_src1),
        .id_src1_en(id_src1_en), .id_src2(id_src2), .id_two_src(id_two_src),
        .branch_taken(branch_taken), .freeze_ext(freeze_ext),
        .hazard(t_haz), .flush(t_flush), .fwd_sel1(t_fs1), .fwd_sel2(t_fs2),
        .stall_cnt(t_scnt), .flush_cnt(t_fcnt)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it when observed differs from expected
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic wb, input logic ld, input logic [3:0] d,
                          input logic [3:0] a, input logic a_en,
                          input logic [3:0] b, input logic b_en);
        id_valid    = 1'b1;
        id_wb_en    = wb;
        id_mem_r_en = ld;
        id_dest     = d;
        id_src1     = a;
        id_src1_en  = a_en;
        id_src2     = b;
        id_two_src  = b_en;
    endtask

    task automatic set_idle();
        id_valid    = 1'b0;
        id_wb_en    = 1'b0;
        id_mem_r_en = 1'b0;
        id_dest     = 4'd0;
        id_src1     = 4'd0;
        id_src1_en  = 1'b0;
        id_src2     = 4'd0;
        id_two_src  = 1'b0;
    endtask

    // Assert reset between clock edges (async), hold 3 edges, release
    task automatic do_reset();
        set_idle();
        branch_taken = 1'b0;
        freeze_ext   = 1'b0;
        rst          = 1'b0;
        #1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst          = 1'b0;
        freeze_ext   = 1'b0;
        branch_taken = 1'b1;
        set_id(1'b1, 1'b0, 4'd1, 4'd1, 1'b1, 4'd1, 1'b1);
        tick();
        check_val("rst_flush",  32'(s_flush), 32'd0);
        check_val("rst_hazard", 32'(s_haz),   32'd0);
        check_val("rst_fsel1",  32'(f_fs1),   32'd0);
        check_val("rst_scnt",   32'(s_scnt),  32'd0);
        check_val("rst_fcnt",   32'(s_fcnt),  32'd0);
        tick();
        tick();
        branch_taken = 1'b0;
        set_idle();
        rst = 1'b1;

        // ---------------- stall-only RAW ----------------
        set_id(1'b1, 1'b0, 4'd1, 4'd2, 1'b1, 4'd3, 1'b1);       // ADD r1, r2, r3
        #1 check_val("first_no_stall", 32'(s_haz), 32'd0);
        tick();
        set_id(1'b1, 1'b0, 4'd2, 4'd1, 1'b1, 4'd3, 1'b1);       // SUB r2, r1, r3
        #1 check_val("so_stall_c1", 32'(s_haz), 32'd1);
        tick();
        #1 check_val("so_stall_c2", 32'(s_haz), 32'd1);
        tick();
        #1 check_val("so_stall_c3", 32'(s_haz), 32'd0);
        check_val("so_stall_cnt", 32'(s_scnt), 32'd2);
        tick();
        set_id(1'b1, 1'b0, 4'd5, 4'd2, 1'b1, 4'd0, 1'b0);       // reads r2 from SUB
        #1 check_val("so_sub_in_exe", 32'(s_haz), 32'd1);

        // mid-operation reset clears counters without waiting for a clock
        rst = 1'b0;
        #1 check_val("async_rst_cnt", 32'(s_scnt), 32'd0);
        rst = 1'b1;
        tick();

        // ---------------- forwarding, back-to-back ----------------
        do_reset();
        set_id(1'b1, 1'b0, 4'd1, 4'd2, 1'b1, 4'd3, 1'b1);       // ADD r1, r2, r3
        tick();
        set_id(1'b1, 1'b0, 4'd4, 4'd1, 1'b1, 4'd1, 1'b1);       // ORR r4, r1, r1
        #1 check_val("fw_no_stall", 32'(f_haz), 32'd0);
        tick();
        set_idle();
        #1 check_val("fw_mem_sel1", 32'(f_fs1), 32'd2);
        check_val("fw_mem_sel2", 32'(f_fs2), 32'd2);
        tick();

        // one independent instruction in between -> forward from WB
        set_id(1'b1, 1'b0, 4'd1, 4'd2, 1'b1, 4'd3, 1'b1);       // ADD r1
        tick();
        set_id(1'b1, 1'b0, 4'd7, 4'd8, 1'b1, 4'd0, 1'b0);       // MOV r7, r8
        tick();
        set_id(1'b1, 1'b0, 4'd4, 4'd1, 1'b1, 4'd1, 1'b1);       // ORR r4, r1, r1
        #1 check_val("fw_gap_no_stall", 32'(f_haz), 32'd0);
        tick();
        set_idle();
        #1 check_val("fw_wb_sel1", 32'(f_fs1), 32'd3);
        check_val("fw_wb_sel2", 32'(f_fs2), 32'd3);
        check_val("fw_scnt", 32'(f_scnt), 32'd0);
        tick();

        // ---------------- load-use ----------------
        do_reset();
        set_id(1'b1, 1'b1, 4'd5, 4'd1, 1'b1, 4'd0, 1'b0);       // LDR r5, [r1]
        tick();
        set_id(1'b1, 1'b0, 4'd6, 4'd5, 1'b1, 4'd0, 1'b1);       // ADD r6, r5, r0
        #1 check_val("lu_stall", 32'(f_haz), 32'd1);
        tick();
        #1 check_val("lu_release", 32'(f_haz), 32'd0);
        tick();
        set_idle();
        #1 check_val("lu_sel1", 32'(f_fs1), 32'd3);
        check_val("lu_sel2", 32'(f_fs2), 32'd0);
        check_val("lu_scnt", 32'(f_scnt), 32'd1);
        tick();

        // ---------------- branch priority ----------------
        do_reset();
        set_id(1'b1, 1'b0, 4'd1, 4'd2, 1'b1, 4'd3, 1'b1);       // ADD r1
        tick();
        set_id(1'b1, 1'b0, 4'd2, 4'd1, 1'b1, 4'd3, 1'b1);       // SUB r2, r1, r3
        branch_taken = 1'b1;
        #1 check_val("br_flush", 32'(s_flush), 32'd1);
        check_val("br_hazard_masked", 32'(s_haz), 32'd0);
        tick();
        branch_taken = 1'b0;
        set_id(1'b0, 1'b0, 4'd0, 4'd2, 1'b1, 4'd0, 1'b0);       // reads r2 only
        #1 check_val("br_fcnt", 32'(s_fcnt), 32'd1);
        check_val("br_scnt", 32'(s_scnt), 32'd0);
        check_val("br_bubble", 32'(s_haz), 32'd0);
        tick();

        // ---------------- saturation (2-bit counters) ----------------
        do_reset();
        set_id(1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0);       // writes r1
        tick();
        for (int i = 1; i <= 3; i++) begin
            set_id(1'b1, 1'b0, 4'(i + 1), 4'(i), 1'b1, 4'd0, 1'b0);
            #1 check_val("sat_haz_a", 32'(t_haz), 32'd1);
            tick();
            #1 check_val("sat_haz_b", 32'(t_haz), 32'd1);
            tick();
            #1 check_val("sat_haz_end", 32'(t_haz), 32'd0);
            check_val("sat_cnt", 32'(t_scnt), (i == 1) ? 32'd2 : 32'd3);
            tick();
        end

        // ---------------- freeze ----------------
        // r4 writer is in EXE; ID reads r4 and a branch is pending
        set_id(1'b1, 1'b0, 4'd5, 4'd4, 1'b1, 4'd0, 1'b0);
        freeze_ext   = 1'b1;
        branch_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1 check_val("frz_hazard", 32'(t_haz), 32'd0);
            check_val("frz_flush", 32'(t_flush), 32'd0);
            tick();
        end
        check_val("frz_scnt", 32'(t_scnt), 32'd3);
        check_val("frz_fcnt", 32'(t_fcnt), 32'd0);
        freeze_ext = 1'b0;
        #1 check_val("unfrz_flush", 32'(t_flush), 32'd1);
        check_val("unfrz_hazard", 32'(t_haz), 32'd0);
        tick();
        branch_taken = 1'b0;
        #1 check_val("unfrz_fcnt", 32'(t_fcnt), 32'd1);
        check_val("frz_entries_held", 32'(t_haz), 32'd1);
        tick();
        set_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the ARM pipeline. It replaces the fixed `freeze = 0` / `branch_taken = 0` tie-offs with a per-stage scoreboard of in-flight destinations. From that scoreboard it generates:
- the ID-stage stall (freeze) and the IF/ID flush;
- EXE operand-forwarding selects, with configurable depth and forwarding mode;
- saturating stall and flush performance counters.

It sits beside ID_Stage and is driven by the ID decode fields and the EXE branch outcome.

## Interface
Parameters:
- STAGES, 3, in-flight stages tracked after ID (1 = EXE, 2 = MEM, 3 = WB); legal range 2..6.
- REG_W, 4, register-address width.
- FWD_EN, 1, 1 = forwarding mode, 0 = stall-only mode.
- RF_WT, 1, 1 = register file writes before reads in the same cycle, so the last stage is excluded from hazard checks.
- CNT_W, 16, width of each performance counter.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, asynchronous, active-low reset.
- id_valid, in, 1, ID holds a real instruction.
- id_wb_en, in, 1, ID instruction writes a register.
- id_mem_r_en, in, 1, ID instruction is a load.
- id_dest, in, REG_W, ID destination register.
- id_src1, in, REG_W, Rn.
- id_src1_en, in, 1, Rn is read.
- id_src2, in, REG_W, Rm / Rd-for-store.
- id_two_src, in, 1, src2 is read.
- branch_taken, in, 1, the instruction in EXE redirects the PC.
- freeze_ext, in, 1, global hold (e.g. memory wait).
- hazard, out, 1, stall IF, IF-reg and ID; insert a bubble into EXE.
- flush, out, 1, clear the IF/ID and ID/EXE registers.
- fwd_sel1, out, 3, forwarding source for the EXE Rn operand.
- fwd_sel2, out, 3, forwarding source for the EXE Rm operand.
- stall_cnt, out, CNT_W, stall cycles counted.
- flush_cnt, out, CNT_W, flush events counted.

## Operation
- Scoreboard entry k (1..STAGES) holds {v, wb, ld, dest}. Entry 1 also holds {src1, src1_en, src2, two_src} of the EXE instruction.
- Advance when freeze_ext = 0:
  - entry k <= entry k-1 for k ≥ 2;
  - entry 1 <= ID fields if id_valid & !hazard & !flush, else a bubble (v = 0).
- When freeze_ext = 1, all entries, counters and outputs hold; hazard and flush are forced to 0.
- A live match means all of: entry v & wb; dest equal to the source; that source enabled.
- Hazard check range: stages 1..STAGES-RF_WT.
- Hazard, FWD_EN = 0: asserts on a live match with any entry in the check range.
- Hazard, FWD_EN = 1: asserts only on a load-use match, i.e. entry 1 has ld = 1 and matches src1 or src2.
- Forwarding:
  - fwd_selN = k (2..STAGES) for the youngest entry k whose live dest matches entry 1's source; 0 means register file.
  - Loads are forwarded only from stage ≥ 3.
  - Forced to 0 when FWD_EN = 0.
- flush = branch_taken & !freeze_ext. Flush has priority: hazard is masked to 0 in the same cycle.
- The branch instruction in entry 1 still advances normally.
- Counters:
  - stall_cnt increments on each hazard cycle.
  - flush_cnt increments on each flush cycle.
  - Both saturate at all-ones and never wrap.

## Timing
- hazard, flush and fwd_sel* are combinational from the current entries and ID inputs, in the same cycle.
- No registered output latency except the counters, which update on the edge after the event.
- Hazard persists until the blocking entry leaves the check range:
  - stall-only mode with RF_WT = 1 and STAGES = 3: at most 2 stall cycles;
  - load-use: exactly 1 stall cycle.
- Reset (rst = 0, asynchronous, also when asserted mid-operation):
  - all entries go invalid; counters go to 0;
  - hazard, flush and fwd_sel* read 0 while reset is held.
- The first instruction after reset release never stalls.
- Simultaneous branch_taken and freeze_ext: freeze wins; the flush is taken in the first unfrozen cycle if branch_taken is still asserted.
- Register 15 receives no special treatment.

## Test plan
- Reset check: hold rst = 0 for 3 cycles, then release -> all outputs 0; counters 0; no hazard on the first id_valid.
- Stall-only mode (FWD_EN = 0, STAGES = 3, RF_WT = 1): ADD r1 in ID, then SUB r2, r1, r3 next -> hazard high for 2 cycles; stall_cnt = 2; the SUB enters EXE on the 3rd cycle.
- Forwarding mode: ADD r1, then immediately ORR r4, r1, r1 -> hazard stays 0. When the ORR is in EXE: fwd_sel1 = 2, fwd_sel2 = 2 (MEM).
  - Insert one independent instruction between them -> both selects = 3 (WB).
- Load-use: LDR r5, then ADD r6, r5, r0 -> exactly 1 stall cycle; then fwd_sel1 = 3; stall_cnt = 1.
- Branch priority: branch_taken = 1 while ID has a RAW hazard -> flush = 1, hazard = 0, flush_cnt = 1; the next entry 1 is a bubble.
- Freeze and saturation: with CNT_W = 2, force 5 hazard cycles -> stall_cnt = 3 (saturated). freeze_ext = 1 for 4 cycles -> entries and counters are unchanged; hazard = 0.
